// File: rtl/version_streamer.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// version_pkg
//   Build identification constants. A build script normally rewrites this
//   package; the values here describe the current release.
// ---------------------------------------------------------------------------
package version_pkg;
  localparam logic [7:0]  C_VERSION_MAJOR  = 8'h00;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'h00;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'h00;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'h39;
  localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;  // BCD
  localparam logic [7:0]  C_VERSION_MONTH  = 8'h11;     // BCD
  localparam logic [7:0]  C_VERSION_DAY    = 8'h07;     // BCD
  localparam logic [7:0]  C_VERSION_HOUR   = 8'h12;     // BCD
  localparam logic [7:0]  C_VERSION_MINUTE = 8'h18;     // BCD
  localparam logic [7:0]  C_VERSION_SECOND = 8'h15;     // BCD
endpackage

// ---------------------------------------------------------------------------
// version_streamer
//   On a request pulse, streams one 14-byte version frame over an
//   AXI-Stream style byte interface:
//     A5 0B MAJOR MINOR PATCH BUILD YEAR_HI YEAR_LO MONTH DAY HOUR MINUTE
//     SECOND CHK
//   CHK makes (length + payload + CHK) mod 256 equal zero; the sync byte is
//   not covered. CHK is built up from the bytes as they leave the block.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        one-cycle pulse requesting a frame
//   m_tdata    frame byte
//   m_tvalid   m_tdata valid (registered, independent of m_tready)
//   m_tready   sink accepts the byte when m_tvalid is also high
//   m_tlast    marks the checksum byte
//   busy       frame in progress or one pending
//   frame_cnt  completed frames, modulo 256
// ---------------------------------------------------------------------------
module version_streamer #(
  parameter logic [7:0]  VER_MAJOR  = version_pkg::C_VERSION_MAJOR,
  parameter logic [7:0]  VER_MINOR  = version_pkg::C_VERSION_MINOR,
  parameter logic [7:0]  VER_PATCH  = version_pkg::C_VERSION_PATCH,
  parameter logic [7:0]  VER_BUILD  = version_pkg::C_VERSION_BUILD,
  parameter logic [15:0] VER_YEAR   = version_pkg::C_VERSION_YEAR,
  parameter logic [7:0]  VER_MONTH  = version_pkg::C_VERSION_MONTH,
  parameter logic [7:0]  VER_DAY    = version_pkg::C_VERSION_DAY,
  parameter logic [7:0]  VER_HOUR   = version_pkg::C_VERSION_HOUR,
  parameter logic [7:0]  VER_MINUTE = version_pkg::C_VERSION_MINUTE,
  parameter logic [7:0]  VER_SECOND = version_pkg::C_VERSION_SECOND
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] LEN_BYTE  = 8'h0B;
  localparam logic [3:0] LAST_IDX  = 4'd13;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t     state;
  logic [3:0] idx;        // index of the byte currently on m_tdata
  logic       pending;    // one queued request, taken at the end of the frame
  logic [7:0] chk_acc;    // running sum of length + payload bytes already sent
  logic       armed;      // low only on the first edge after reset release

  // Fixed frame contents; index 13 (checksum) is produced from chk_acc.
  function automatic logic [7:0] field_byte(input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = LEN_BYTE;
      4'd2:    b = VER_MAJOR;
      4'd3:    b = VER_MINOR;
      4'd4:    b = VER_PATCH;
      4'd5:    b = VER_BUILD;
      4'd6:    b = VER_YEAR[15:8];
      4'd7:    b = VER_YEAR[7:0];
      4'd8:    b = VER_MONTH;
      4'd9:    b = VER_DAY;
      4'd10:   b = VER_HOUR;
      4'd11:   b = VER_MINUTE;
      4'd12:   b = VER_SECOND;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic       handshake;
  logic       req_ok;
  logic [3:0] idx_next;
  logic [7:0] acc_next;
  logic [7:0] byte_next;

  assign handshake = m_tvalid & m_tready;
  assign req_ok    = req & armed;
  assign idx_next  = idx + 4'd1;
  assign busy      = (state == SEND) | pending;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    acc_next  = chk_acc;
    byte_next = 8'h00;
    // The byte leaving now joins the sum unless it is the sync byte.
    if ((idx != 4'd0) && (idx != LAST_IDX)) begin
      acc_next = chk_acc + m_tdata;
    end
    if (idx_next == LAST_IDX) begin
      byte_next = 8'h00 - acc_next;
    end else begin
      byte_next = field_byte(idx_next);
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      pending   <= 1'b0;
      chk_acc   <= 8'h00;
      m_tdata   <= 8'h00;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      frame_cnt <= 8'h00;
      armed     <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (req_ok) begin
            state    <= SEND;
            idx      <= 4'd0;
            chk_acc  <= 8'h00;
            m_tdata  <= SYNC_BYTE;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
          end
        end

        SEND: begin
          // A request during a frame is remembered once; repeats are dropped.
          if (req_ok) begin
            pending <= 1'b1;
          end
          if (handshake) begin
            if (idx == LAST_IDX) begin
              frame_cnt <= frame_cnt + 8'd1;
              chk_acc   <= 8'h00;
              idx       <= 4'd0;
              m_tlast   <= 1'b0;
              // A request landing on the final handshake counts as pending;
              // restarting here keeps m_tvalid high across the boundary.
              if (pending || req_ok) begin
                pending  <= 1'b0;
                m_tdata  <= SYNC_BYTE;
                m_tvalid <= 1'b1;
              end else begin
                state    <= IDLE;
                m_tdata  <= 8'h00;
                m_tvalid <= 1'b0;
              end
            end else begin
              idx     <= idx_next;
              chk_acc <= acc_next;
              m_tdata <= byte_next;
              m_tlast <= (idx_next == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_version_streamer.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// tb_version_streamer
//   Self-checking bench for version_streamer. A second instance built with
//   VER_BUILD = 8'hFF covers the alternate build number and its checksum.
// ---------------------------------------------------------------------------
module tb_version_streamer;

  // Release values the reference frame is built from.
  localparam logic [7:0]  D_MAJOR  = 8'h00;
  localparam logic [7:0]  D_MINOR  = 8'h00;
  localparam logic [7:0]  D_PATCH  = 8'h00;
  localparam logic [7:0]  D_BUILD  = 8'h39;
  localparam logic [15:0] D_YEAR   = 16'h2025;
  localparam logic [7:0]  D_MONTH  = 8'h11;
  localparam logic [7:0]  D_DAY    = 8'h07;
  localparam logic [7:0]  D_HOUR   = 8'h12;
  localparam logic [7:0]  D_MINUTE = 8'h18;
  localparam logic [7:0]  D_SECOND = 8'h15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       busy;
  logic [7:0] frame_cnt;

  logic       req2;
  logic       m_tready2;
  logic [7:0] m_tdata2;
  logic       m_tvalid2;
  logic       m_tlast2;
  logic       busy2;
  logic [7:0] frame_cnt2;

  always #5 clk = ~clk;

  version_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  version_streamer #(.VER_BUILD(8'hFF)) dut_ff (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req2),
    .m_tdata   (m_tdata2),
    .m_tvalid  (m_tvalid2),
    .m_tready  (m_tready2),
    .m_tlast   (m_tlast2),
    .busy      (busy2),
    .frame_cnt (frame_cnt2)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] got_q[$];
  logic       last_q[$];
  logic [7:0] got2[$];
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;
  int         model_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame built straight from the frame layout and checksum rule.
  function automatic logic [13:0][7:0] model_frame(input logic [7:0] build);
    logic [13:0][7:0] f;
    int sum;
    f[0]  = 8'hA5;
    f[1]  = 8'h0B;
    f[2]  = D_MAJOR;
    f[3]  = D_MINOR;
    f[4]  = D_PATCH;
    f[5]  = build;
    f[6]  = D_YEAR[15:8];
    f[7]  = D_YEAR[7:0];
    f[8]  = D_MONTH;
    f[9]  = D_DAY;
    f[10] = D_HOUR;
    f[11] = D_MINUTE;
    f[12] = D_SECOND;
    sum = 0;
    for (int i = 1; i <= 12; i++) sum += int'(f[i]);
    f[13] = 8'((256 - (sum % 256)) % 256);
    return f;
  endfunction

  // One clock of traffic on the main instance: sample outputs on the falling
  // edge, check stall stability, then drive inputs for the next rising edge.
  task automatic step(input bit rnd, input bit req_now, input logic [13:0] req_mask);
    int idx;
    @(negedge clk);
    idx = got_q.size() % 14;
    if (stall_prev) begin
      check("stall_valid", m_tvalid, 1);
      check("stall_data", m_tdata, stall_data);
      check("stall_last", m_tlast, stall_last);
    end
    if (m_tvalid) check($sformatf("tlast_at_idx%0d", idx), m_tlast, (idx == 13));
    m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    req = req_now | (m_tvalid & req_mask[idx] & (got_q.size() < 14));
    if (m_tvalid && m_tready) begin
      got_q.push_back(m_tdata);
      last_q.push_back(m_tlast);
    end
    stall_prev = m_tvalid && !m_tready;
    stall_data = m_tdata;
    stall_last = m_tlast;
  endtask

  task automatic run_frame(input bit rnd, input string tag);
    int budget;
    step(rnd, 1'b1, 14'h0);
    budget = 400;
    do begin
      step(rnd, 1'b0, 14'h0);
      budget--;
    end while ((busy || m_tvalid) && budget > 0);
    if (budget == 0) check({tag, "_timeout_busy"}, busy, 0);
    model_frames++;
  endtask

  // Compare everything accepted so far against n reference frames.
  task automatic verify(input int n, input string tag);
    logic [13:0][7:0] f;
    int lim;
    f = model_frame(D_BUILD);
    check({tag, "_byte_count"}, got_q.size(), 14 * n);
    lim = (got_q.size() < 14 * n) ? got_q.size() : 14 * n;
    for (int i = 0; i < lim; i++) begin
      check($sformatf("%s_byte%0d", tag, i), got_q[i], f[i % 14]);
      check($sformatf("%s_last%0d", tag, i), last_q[i], ((i % 14) == 13));
    end
    check({tag, "_frame_cnt"}, frame_cnt, 8'(model_frames));
    got_q.delete();
    last_q.delete();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    check({tag, "_rst_tvalid"}, m_tvalid, 0);
    check({tag, "_rst_tlast"}, m_tlast, 0);
    check({tag, "_rst_tdata"}, m_tdata, 0);
    check({tag, "_rst_busy"}, busy, 0);
    check({tag, "_rst_frame_cnt"}, frame_cnt, 0);
    check({tag, "_rst_tvalid_ff"}, m_tvalid2, 0);
    repeat (3) @(negedge clk);
    // A request on the first edge after release must be ignored.
    rst_n    = 1'b1;
    req      = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check({tag, "_post_rel_busy"}, busy, 0);
    check({tag, "_post_rel_tvalid"}, m_tvalid, 0);
    got_q.delete();
    last_q.delete();
    stall_prev   = 1'b0;
    model_frames = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion by time limit, expected bench to finish");
    $fatal(1);
  end

  initial begin
    bit bnd;
    int prior;
    int budget;

    rst_n     = 1'b0;
    req       = 1'b0;
    m_tready  = 1'b0;
    req2      = 1'b0;
    m_tready2 = 1'b1;

    do_reset("init");

    // Single frame, sink always ready.
    run_frame(1'b0, "basic");
    check("basic_chk_literal", got_q[13], 8'h20);
    check("basic_busy_after", busy, 0);
    verify(1, "basic");

    // Random backpressure over several frames.
    for (int k = 0; k < 3; k++) run_frame(1'b1, "bp");
    verify(3, "bp");

    // Requests at index 5, 9 and on the final handshake: exactly two frames.
    step(1'b0, 1'b1, 14'h0);
    bnd = 1'b0;
    budget = 200;
    do begin
      prior = got_q.size();
      step(1'b0, 1'b0, 14'h2220);
      if (prior == 14 && !bnd) begin
        bnd = 1'b1;
        check("b2b_boundary_tvalid", m_tvalid, 1);
        check("b2b_boundary_tdata", m_tdata, 8'hA5);
      end
      budget--;
    end while ((busy || m_tvalid) && budget > 0);
    if (budget == 0) check("b2b_timeout_busy", busy, 0);
    model_frames += 2;
    verify(2, "b2b");

    // Alternate build number on the second instance.
    @(negedge clk);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (m_tvalid2) got2.push_back(m_tdata2);
      @(negedge clk);
    end
    check("ff_byte_count", got2.size(), 14);
    if (got2.size() == 14) begin
      logic [13:0][7:0] fff;
      fff = model_frame(8'hFF);
      check("ff_byte5_literal", got2[5], 8'hFF);
      check("ff_chk_literal", got2[13], 8'h5A);
      for (int i = 0; i < 14; i++) check($sformatf("ff_byte%0d", i), got2[i], fff[i]);
    end
    check("ff_frame_cnt", frame_cnt2, 1);
    check("ff_busy_after", busy2, 0);

    // Reset mid-frame at index 7 under backpressure.
    step(1'b1, 1'b1, 14'h0);
    budget = 200;
    while (got_q.size() < 7 && budget > 0) begin
      step(1'b1, 1'b0, 14'h0);
      budget--;
    end
    check("midrst_reached_idx7", got_q.size(), 7);
    do_reset("midrst");
    run_frame(1'b1, "after_rst");
    verify(1, "after_rst");

    // Frame counter wrap.
    while (model_frames < 256) begin
      run_frame(1'b0, "wrap");
      got_q.delete();
      last_q.delete();
    end
    check("wrap_256_frame_cnt", frame_cnt, 8'h00);
    run_frame(1'b0, "wrap257");
    check("wrap_257_literal", frame_cnt, 8'h01);
    verify(1, "wrap257");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
